// File: rtl/fib_req_sequencer.sv
// rtl/fib_req_sequencer.sv - request FIFO + one-at-a-time issue to fibonacci_gen; optional watchdog via FIB_SEQ_TIMEOUT_EN
module fib_req_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int MAX_N = 13,
    parameter int TMO   = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_n_i,
    output logic             gen_start_o,
    output logic [WIDTH-1:0] gen_n_o,
    input  logic             gen_done_i,
    input  logic [WIDTH-1:0] gen_fib_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_n_o,
    output logic [WIDTH-1:0] rsp_fib_o,
    output logic             rsp_ovf_o,
    output logic             rsp_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]      DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] MAX_N_C = WIDTH'(MAX_N);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] head;

    logic             gen_start_q, gen_start_d;
    logic [WIDTH-1:0] gen_n_q, gen_n_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_n_q, rsp_n_d;
    logic [WIDTH-1:0] rsp_fib_q, rsp_fib_d;
    logic             rsp_ovf_q, rsp_ovf_d;

`ifdef FIB_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rsp_err_q, rsp_err_d;
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign req_ready_o = !full && !rst_i;
    assign push        = req_valid_i && req_ready_o;
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= req_n_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // gen_done while gen_start_q is still high belongs to no request we issued yet
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        gen_start_d = 1'b0;
        gen_n_d     = gen_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_n_d     = rsp_n_q;
        rsp_fib_d   = rsp_fib_q;
        rsp_ovf_d   = rsp_ovf_q;
`ifdef FIB_SEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head > MAX_N_C) begin
                        rsp_n_d     = head;
                        rsp_fib_d   = '1;
                        rsp_ovf_d   = 1'b1;
                        rsp_valid_d = 1'b1;
`ifdef FIB_SEQ_TIMEOUT_EN
                        rsp_err_d   = 1'b0;
`endif
                        state_d     = S_RESP;
                    end else begin
                        gen_start_d = 1'b1;
                        gen_n_d     = head;
`ifdef FIB_SEQ_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (gen_done_i && !gen_start_q) begin
                    rsp_fib_d   = gen_fib_i;
                    rsp_n_d     = gen_n_q;
                    rsp_ovf_d   = 1'b0;
                    rsp_valid_d = 1'b1;
`ifdef FIB_SEQ_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef FIB_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_fib_d   = '0;
                    rsp_n_d     = gen_n_q;
                    rsp_ovf_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + TW'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            gen_start_q <= 1'b0;
            gen_n_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_n_q     <= '0;
            rsp_fib_q   <= '0;
            rsp_ovf_q   <= 1'b0;
`ifdef FIB_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gen_start_q <= gen_start_d;
            gen_n_q     <= gen_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_n_q     <= rsp_n_d;
            rsp_fib_q   <= rsp_fib_d;
            rsp_ovf_q   <= rsp_ovf_d;
`ifdef FIB_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign gen_start_o = gen_start_q;
    assign gen_n_o     = gen_n_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_n_o     = rsp_n_q;
    assign rsp_fib_o   = rsp_fib_q;
    assign rsp_ovf_o   = rsp_ovf_q;
endmodule

// File: tb/tb_fib_req_sequencer.sv
// tb/tb_fib_req_sequencer.sv - scoreboard bench for fib_req_sequencer with a behavioural generator
module tb_fib_req_sequencer;
    logic       clk, rst;
    logic       req_valid, req_ready;
    logic [7:0] req_n;
    logic       gen_start, gen_done, gdm, gds;
    logic [7:0] gen_n, gen_fib;
    logic       rsp_valid, rsp_ready, rsp_ovf, rsp_err;
    logic [7:0] rsp_n, rsp_fib;

    int errors = 0;
    int checks = 0;
    int gen_lat = 3;
    bit gen_en = 1'b1;

    typedef struct packed {
        logic [7:0] n;
        logic [7:0] fib;
        logic       ovf;
        logic       err;
    } rsp_t;
    rsp_t       exp_q[$];
    logic [7:0] gen_q[$];

    assign gen_done = gdm | gds;

    fib_req_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_n_i(req_n),
        .gen_start_o(gen_start), .gen_n_o(gen_n),
        .gen_done_i(gen_done), .gen_fib_i(gen_fib),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_n_o(rsp_n), .rsp_fib_o(rsp_fib), .rsp_ovf_o(rsp_ovf), .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fib_tab(input logic [7:0] n);
        case (n)
            8'd0:    return 8'd0;
            8'd1:    return 8'd1;
            8'd3:    return 8'd2;
            8'd5:    return 8'd5;
            8'd7:    return 8'd13;
            8'd9:    return 8'd34;
            8'd10:   return 8'd55;
            8'd12:   return 8'd144;
            default: return 8'hEE;
        endcase
    endfunction

    // Generator model: replies gen_lat cycles after seeing gen_start
    initial begin
        logic [7:0] gn;
        gdm = 1'b0;
        gen_fib = 8'd0;
        forever begin
            @(negedge clk);
            if (gen_start && gen_en && !rst) begin
                gn = gen_n;
                repeat (gen_lat - 1) @(posedge clk);
                #1 gdm = 1'b1;
                gen_fib = fib_tab(gn);
                @(posedge clk);
                #1 gdm = 1'b0;
                @(negedge clk);
                chk("rsp_valid_after_done", {31'd0, rsp_valid}, 32'd1);
            end
        end
    end

    // Generator-side monitor: every gen_start must match the next expected index
    always @(negedge clk) begin
        if (!rst && gen_start) begin
            if (gen_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL gen_start_unexpected: gen_n=%0d with no expected issue", gen_n);
            end else begin
                chk("gen_n", {24'd0, gen_n}, {24'd0, gen_q.pop_front()});
            end
        end
    end

    // Response monitor: hold-while-stalled and in-order scoreboard compare
    bit   p_stall = 1'b0;
    rsp_t p_rsp;
    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall)
                chk("rsp_hold", {14'd0, rsp_valid, rsp_n, rsp_fib, rsp_ovf, rsp_err},
                    {14'd0, 1'b1, p_rsp});
            p_stall = rsp_valid && !rsp_ready;
            p_rsp   = '{n: rsp_n, fib: rsp_fib, ovf: rsp_ovf, err: rsp_err};
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: n=%0d fib=%0d", rsp_n, rsp_fib);
                end else begin
                    chk("rsp", {14'd0, rsp_n, rsp_fib, rsp_ovf, rsp_err},
                        {14'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic push(input logic [7:0] n, input logic [7:0] fib, input logic ovf,
                        input logic to_gen, input logic err);
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++; errors++;
            $display("FAIL push_timeout: n=%0d req_ready stuck low", n);
        end
        req_valid = 1'b1;
        req_n = n;
        @(posedge clk);
        #1 req_valid = 1'b0;
        exp_q.push_back('{n: n, fib: fib, ovf: ovf, err: err});
        if (to_gen) gen_q.push_back(n);
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rsp_valid) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_n = 8'd0; rsp_ready = 1'b0; gds = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_gen", {23'd0, gen_start, gen_n}, 32'd0);
        chk("rst_rsp", {13'd0, rsp_valid, rsp_n, rsp_fib, rsp_ovf, rsp_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        // 1: n=10, slow generator, start latency
        rsp_ready = 1'b1;
        gen_lat = 12;
        push(8'd10, 8'd55, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("start_not_yet", {31'd0, gen_start}, 32'd0);
        @(negedge clk);
        chk("start_latency", {23'd0, gen_start, gen_n}, {23'd0, 1'b1, 8'd10});
        drain();
        gen_lat = 3;

        // 2: fill FIFO behind an in-flight request with consumer stalled
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        push(8'd3,  8'd2,   1'b0, 1'b1, 1'b0);
        push(8'd5,  8'd5,   1'b0, 1'b1, 1'b0);
        push(8'd7,  8'd13,  1'b0, 1'b1, 1'b0);
        push(8'd9,  8'd34,  1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ready_3_queued", {31'd0, req_ready}, 32'd1);
        push(8'd12, 8'd144, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ready_full", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        req_n = 8'd1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // 3: overflow index bypasses the generator
        push(8'd14, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();

        // 4: smallest indices
        push(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        push(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
        drain();

        // 5: reset while WAIT with two queued
        gen_en = 1'b0;
        push(8'd4, 8'd3, 1'b0, 1'b1, 1'b0);
        push(8'd5, 8'd5, 1'b0, 1'b1, 1'b0);
        push(8'd6, 8'd8, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_gen", {23'd0, gen_start, gen_n}, 32'd0);
        chk("midrst_rsp", {13'd0, rsp_valid, rsp_n, rsp_fib, rsp_ovf, rsp_err}, 32'd0);
        exp_q.delete();
        gen_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("postrst_quiet", {30'd0, rsp_valid, gen_start}, 32'd0);
        end
        @(posedge clk);
        #1 gds = 1'b1;
        @(posedge clk);
        #1 gds = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stray_done_ignored", {31'd0, rsp_valid}, 32'd0);
        end
        gen_en = 1'b1;

`ifdef FIB_SEQ_TIMEOUT_EN
        // 6: watchdog fires 64 cycles after entering WAIT
        begin
            int g = 0;
            int cyc = 0;
            gen_en = 1'b0;
            push(8'd6, 8'd0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            while (!gen_start && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("tmo_start_seen", {31'd0, gen_start}, 32'd1);
            while (!rsp_valid && cyc < 200) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            chk("tmo_cycles", cyc, 32'd64);
            drain();
            @(posedge clk);
            #1 gds = 1'b1;
            @(posedge clk);
            #1 gds = 1'b0;
            repeat (5) begin
                @(negedge clk);
                chk("late_done_ignored", {31'd0, rsp_valid}, 32'd0);
            end
            gen_en = 1'b1;
        end
`endif

        repeat (3) @(negedge clk);
        chk("exp_rsp_left", exp_q.size(), 32'd0);
        chk("exp_gen_left", gen_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
